// File: rtl/rs_syndrome_ctrl_if.sv
// Handshake bundle between the RS(18,16) syndrome sequencer and its neighbours.
// RS_ERR_CNT_EN adds the saturating err_count signal.
interface rs_syndrome_ctrl_if #(
    parameter int N            = 18,
    parameter int SYMBOL_WIDTH = 8
`ifdef RS_ERR_CNT_EN
    ,
    parameter int CNT_WIDTH    = 16
`endif
);
    logic                        in_valid;
    logic                        in_ready;
    logic [SYMBOL_WIDTH-1:0]     in_sym;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [N*SYMBOL_WIDTH-1:0]   out_cw;
    logic [SYMBOL_WIDTH-1:0]     out_s1;
    logic [SYMBOL_WIDTH-1:0]     out_s2;
    logic                        out_err;
    logic                        frame_err;
`ifdef RS_ERR_CNT_EN
    logic [CNT_WIDTH-1:0]        err_count;
`endif

    modport master (
        output in_valid, in_sym, in_last, out_ready,
        input  in_ready, out_valid, out_cw, out_s1, out_s2, out_err, frame_err
`ifdef RS_ERR_CNT_EN
        , input err_count
`endif
    );

    modport slave (
        input  in_valid, in_sym, in_last, out_ready,
        output in_ready, out_valid, out_cw, out_s1, out_s2, out_err, frame_err
`ifdef RS_ERR_CNT_EN
        , output err_count
`endif
    );
endinterface

// File: rtl/rs_syndrome_ctrl.sv
// RS(18,16) GF(2^8) syndrome sequencer: serial symbol collect, one-cycle syndrome calc, valid/ready output.
// Optional feature macro: RS_ERR_CNT_EN (saturating count of erroneous codewords handed off).
module rs_compute_s #(
    parameter int                N    = 18,
    parameter int                W    = 8,
    parameter logic [W-1:0]      POLY = 8'h1D
) (
    input  logic [N*W-1:0] cw_i,
    output logic [W-1:0]   s1_o,
    output logic [W-1:0]   s2_o
);
    function automatic logic [W-1:0] xt(input logic [W-1:0] a);
        xt = {a[W-2:0], 1'b0} ^ ({W{a[W-1]}} & POLY);
    endfunction

    // Horner evaluation at alpha and alpha^2; first symbol is the highest-degree coefficient.
    always_comb begin
        s1_o = '0;
        s2_o = '0;
        for (int i = 0; i < N; i++) begin
            s1_o = xt(s1_o) ^ cw_i[(N-1-i)*W +: W];
            s2_o = xt(xt(s2_o)) ^ cw_i[(N-1-i)*W +: W];
        end
    end
endmodule

module rs_syndrome_ctrl #(
    parameter int N            = 18,
    parameter int SYMBOL_WIDTH = 8
`ifdef RS_ERR_CNT_EN
    ,
    parameter int CNT_WIDTH    = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    rs_syndrome_ctrl_if.slave bus
);
    localparam int W    = SYMBOL_WIDTH;
    localparam int CW_W = $clog2(N);
    localparam logic [CW_W-1:0] LAST_IDX = CW_W'(N-1);

    typedef enum logic [1:0] {COLLECT, CALC, OUT} state_t;

    state_t            state_q, state_d;
    logic [N*W-1:0]    cw_q;
    logic [CW_W-1:0]   count_q;
    logic [N*W-1:0]    out_cw_q;
    logic [W-1:0]      s1_q, s2_q;
    logic              err_q;
    logic              frame_err_q;
    logic [W-1:0]      s1_c, s2_c;
    logic              accept;

    rs_compute_s #(.N(N), .W(W)) u_compute_s (
        .cw_i (cw_q),
        .s1_o (s1_c),
        .s2_o (s2_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && count_q == LAST_IDX) state_d = CALC;
            CALC:    state_d = OUT;
            OUT:     if (bus.out_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == COLLECT);
        bus.out_valid = (state_q == OUT);
    end

    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_q        <= '0;
            count_q     <= '0;
            out_cw_q    <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            err_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (accept) begin
                cw_q <= {cw_q[(N-1)*W-1:0], bus.in_sym};
                // A late or missing in_last still completes the codeword; an early one drops the frame.
                if (count_q == LAST_IDX) begin
                    count_q     <= '0;
                    frame_err_q <= ~bus.in_last;
                end else if (bus.in_last) begin
                    count_q     <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
            if (state_q == CALC) begin
                out_cw_q <= cw_q;
                s1_q     <= s1_c;
                s2_q     <= s2_c;
                err_q    <= |{s1_c, s2_c};
            end
        end
    end

    assign bus.out_cw    = out_cw_q;
    assign bus.out_s1    = s1_q;
    assign bus.out_s2    = s2_q;
    assign bus.out_err   = err_q;
    assign bus.frame_err = frame_err_q;

`ifdef RS_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt_q <= '0;
        else if (bus.out_valid && bus.out_ready && err_q && err_cnt_q != {CNT_WIDTH{1'b1}})
            err_cnt_q <= err_cnt_q + 1'b1;
    end

    assign bus.err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// Directed table-driven bench for rs_syndrome_ctrl with a GF(2^8) golden syndrome model.
// Build with RS_ERR_CNT_EN to also exercise the saturating error counter (CNT_WIDTH=2).
module tb_rs_syndrome_ctrl;
    localparam int N   = 18;
    localparam int CWB = N*8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_syndrome_ctrl_if #(
        .N(N), .SYMBOL_WIDTH(8)
`ifdef RS_ERR_CNT_EN
        , .CNT_WIDTH(2)
`endif
    ) bus ();

    rs_syndrome_ctrl #(
        .N(N), .SYMBOL_WIDTH(8)
`ifdef RS_ERR_CNT_EN
        , .CNT_WIDTH(2)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [CWB-1:0] cw;
        logic [7:0]     s1;
        logic [7:0]     s2;
        logic           err;
        int             hold;
    } vec_t;

    vec_t tbl[6];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    // Generic shift-and-add multiply over x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] gpow(input int e);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < e; i++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [7:0] gold_s(input logic [CWB-1:0] cw, input int j);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < N; i++)
            s = s ^ gmul(cw[(N-1-i)*8 +: 8], gpow(j*(N-1-i)));
        return s;
    endfunction

    task automatic chk(input string nm, input logic [CWB-1:0] act, input logic [CWB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] s, input logic l);
        int t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk("push_ready_timeout", {143'd0, bus.in_ready}, 1);
        bus.in_valid = 1'b1;
        bus.in_sym   = s;
        bus.in_last  = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [CWB-1:0] cw, input logic last_ok);
        for (int i = 0; i < N; i++)
            push(cw[(N-1-i)*8 +: 8], (i == N-1) && last_ok);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  {143'd0, bus.in_ready}, 1);
        chk({tag, "_out_valid"}, {143'd0, bus.out_valid}, 0);
        chk({tag, "_out_cw"},    bus.out_cw, 0);
        chk({tag, "_s1s2err"},   {127'd0, bus.out_s1, bus.out_s2, bus.out_err}, 0);
        chk({tag, "_frame_err"}, {143'd0, bus.frame_err}, 0);
`ifdef RS_ERR_CNT_EN
        chk({tag, "_err_count"}, {142'd0, bus.err_count}, 0);
`endif
    endtask

    // Called 1ns after the edge that accepted the final symbol.
    task automatic get_result(input string tag, input vec_t v);
        chk({tag, "_calc_no_valid"}, {142'd0, bus.out_valid, bus.in_ready}, 0);
        @(posedge clk);
        #1;
        chk({tag, "_out_valid"}, {143'd0, bus.out_valid}, 1);
        chk({tag, "_out_cw"}, bus.out_cw, v.cw);
        chk({tag, "_s1s2err"}, {127'd0, bus.out_s1, bus.out_s2, bus.out_err}, {127'd0, v.s1, v.s2, v.err});
        for (int h = 0; h < v.hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_sym   = 8'($urandom);
            bus.in_last  = 1'($urandom);
            @(posedge clk);
            #1;
            chk({tag, "_hold"}, {142'd0, bus.out_valid, bus.in_ready}, 2);
            chk({tag, "_hold_cw"}, bus.out_cw, v.cw);
            chk({tag, "_hold_s"}, {127'd0, bus.out_s1, bus.out_s2, bus.out_err}, {127'd0, v.s1, v.s2, v.err});
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_after_hs"}, {142'd0, bus.out_valid, bus.in_ready}, 1);
        if (v.err) exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
`ifdef RS_ERR_CNT_EN
        chk({tag, "_err_count"}, {142'd0, bus.err_count}, CWB'(exp_cnt));
`endif
    endtask

    initial begin
        logic [CWB-1:0] r;
        bus.in_valid  = 1'b0;
        bus.in_sym    = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        tbl[0] = '{cw: '0, s1: 8'h00, s2: 8'h00, err: 1'b0, hold: 0};
        r = '0; r[CWB-1 -: 8] = 8'h01;
        tbl[1] = '{cw: r, s1: 8'h98, s2: 8'h4E, err: 1'b1, hold: 0};
        r = '0; r[7:0] = 8'h01;
        tbl[2] = '{cw: r, s1: 8'h01, s2: 8'h01, err: 1'b1, hold: 0};
        r = '0; r[23:0] = 24'h010608;  // generator polynomial itself: a valid codeword
        tbl[3] = '{cw: r, s1: 8'h00, s2: 8'h00, err: 1'b0, hold: 2};
        for (int i = 0; i < N; i++) r[i*8 +: 8] = 8'(8'h11 * (i + 1) ^ 8'hA5);
        tbl[4] = '{cw: r, s1: gold_s(r, 1), s2: gold_s(r, 2), err: |{gold_s(r, 1), gold_s(r, 2)}, hold: 5};
        for (int i = 0; i < N; i++) r[i*8 +: 8] = (i % 2) ? 8'hFF : 8'h80;
        tbl[5] = '{cw: r, s1: gold_s(r, 1), s2: gold_s(r, 2), err: |{gold_s(r, 1), gold_s(r, 2)}, hold: 1};

        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            send_frame(tbl[k].cw, 1'b1);
            chk($sformatf("vec%0d_no_frame_err", k), {143'd0, bus.frame_err}, 0);
            get_result($sformatf("vec%0d", k), tbl[k]);
        end

        // Short frame: in_last on the 5th symbol drops it.
        for (int i = 0; i < 5; i++) push(8'hC3, i == 4);
        chk("short_frame_err", {142'd0, bus.frame_err, bus.out_valid}, 2);
        @(posedge clk);
        #1;
        chk("short_frame_pulse_end", {142'd0, bus.frame_err, bus.out_valid}, 0);
        send_frame(tbl[4].cw, 1'b1);
        get_result("after_short", tbl[4]);

        // Long frame: no in_last on symbol 18 flags but still completes.
        send_frame(tbl[5].cw, 1'b0);
        chk("long_frame_err", {143'd0, bus.frame_err}, 1);
        get_result("long_frame", tbl[5]);

        // Reset mid-frame.
        for (int i = 0; i < 10; i++) push(8'h5A, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset_vals("midreset");
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        send_frame(tbl[2].cw, 1'b1);
        get_result("after_reset", tbl[2]);

`ifdef RS_ERR_CNT_EN
        for (int k = 0; k < 5; k++) begin
            send_frame(tbl[1].cw, 1'b1);
            get_result($sformatf("sat%0d", k), tbl[1]);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
